// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: edge-mask modes and default kernel geometry.
package conv_pkg;

    typedef enum logic [1:0] {
        MASK_ZERO      = 2'd0,
        MASK_CONST     = 2'd1,
        MASK_REPLICATE = 2'd2
    } mask_mode_t;

    localparam int DEF_KERNEL_N = 5;
    localparam int DEF_PIXEL_W  = 8;
    localparam int KERNEL_R     = (DEF_KERNEL_N - 1) / 2;

    typedef logic [DEF_KERNEL_N*DEF_KERNEL_N*DEF_PIXEL_W-1:0] kernel_n_t;

endpackage

// File: rtl/conv_mask_clamp.sv
// One image axis of the edge mask: which kernel offsets fall off the image and,
// for replication, which in-window index each offset should borrow from.
module conv_mask_clamp #(
    parameter int  KERNEL_N = 5,
    parameter int  PW       = 11,
    parameter int  EW       = 12,
    localparam int IW       = $clog2(KERNEL_N)
) (
    input  logic [PW-1:0]          pos,
    input  logic [EW-1:0]          extent,
    output logic [KERNEL_N-1:0]    outside,
    output logic [KERNEL_N*IW-1:0] idx
);

    localparam int R  = (KERNEL_N - 1) / 2;
    localparam int SW = ((PW > EW) ? PW : EW) + 2;

    logic signed [SW-1:0] pos_s, ext_s, lo, hi, p, c;

    // Valid window indices along this axis span [R-pos, R+extent-1-pos].
    always_comb begin
        pos_s   = $signed(SW'(pos));
        ext_s   = $signed(SW'(extent));
        lo      = SW'(R) - pos_s;
        hi      = SW'(R) + ext_s - SW'(1) - pos_s;
        outside = '0;
        idx     = '0;
        p       = '0;
        c       = '0;
        for (int k = 0; k < KERNEL_N; k++) begin
            p          = pos_s + SW'(k - R);
            outside[k] = p[SW-1] || (p >= ext_s);
            c          = SW'(k);
            if (c < lo) c = lo;
            if (c > hi) c = hi;
            if (c[SW-1]) c = '0;
            if (c > SW'(KERNEL_N - 1)) c = SW'(KERNEL_N - 1);
            idx[k*IW +: IW] = c[IW-1:0];
        end
    end

endmodule

// File: rtl/conv_mask_stream.sv
// Streaming KxK window edge mask: tracks the window centre, applies ZERO/CONST/REPLICATE
// to off-image taps and registers the result behind a valid/ready output stage.
module conv_mask_stream
    import conv_pkg::*;
#(
    parameter int  KERNEL_N  = DEF_KERNEL_N,
    parameter int  PIXEL_W   = DEF_PIXEL_W,
    parameter int  IMG_W_MAX = 1920,
    parameter int  IMG_H_MAX = 1080,
    localparam int CW        = $clog2(IMG_W_MAX),
    localparam int RW        = $clog2(IMG_H_MAX),
    localparam int KW        = KERNEL_N * KERNEL_N * PIXEL_W
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [1:0]         cfg_mode_i,
    input  logic [PIXEL_W-1:0] cfg_const_i,
    input  logic [CW:0]        cfg_w_i,
    input  logic [RW:0]        cfg_h_i,
    input  logic               in_vld_i,
    output logic               in_rdy_o,
    input  logic               in_sof_i,
    input  logic [KW-1:0]      in_kernel_i,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic               out_sof_o,
    output logic               out_eol_o,
    output logic               out_eof_o,
    output logic [KW-1:0]      out_kernel_o,
    output logic               err_o
);

    localparam int IW = $clog2(KERNEL_N);

    logic [CW-1:0]       col_q, cur_col;
    logic [RW-1:0]       row_q, cur_row;
    logic                in_frame_q, start, accept, eol, eof;
    logic [1:0]          mode_q, eff_mode;
    logic [PIXEL_W-1:0]  const_q, eff_const;
    logic [CW:0]         w_q, eff_w;
    logic [RW:0]         h_q, eff_h;
    logic [KERNEL_N-1:0] row_out, col_out;
    logic [KERNEL_N*IW-1:0] row_idx, col_idx;
    logic [KW-1:0]       masked;
    int                  src;

    // Handshake: a beat transfers on a side when valid & ready are both high at the
    // clock edge; the output register holds its contents while valid and not ready.
    assign in_rdy_o = !out_vld_o || out_rdy_i;
    assign accept   = in_vld_i && in_rdy_o;

    // A beat outside a frame is handled as a frame start using the held config.
    assign start     = in_sof_i || !in_frame_q;
    assign cur_col   = start ? '0 : col_q;
    assign cur_row   = start ? '0 : row_q;
    assign eff_mode  = in_sof_i ? cfg_mode_i  : mode_q;
    assign eff_const = in_sof_i ? cfg_const_i : const_q;
    assign eff_w     = in_sof_i ? cfg_w_i     : w_q;
    assign eff_h     = in_sof_i ? cfg_h_i     : h_q;
    assign eol       = ({1'b0, cur_col} == eff_w - 1'b1);
    assign eof       = eol && ({1'b0, cur_row} == eff_h - 1'b1);

    conv_mask_clamp #(.KERNEL_N(KERNEL_N), .PW(RW), .EW(RW + 1)) u_row_clamp (
        .pos     (cur_row),
        .extent  (eff_h),
        .outside (row_out),
        .idx     (row_idx)
    );

    conv_mask_clamp #(.KERNEL_N(KERNEL_N), .PW(CW), .EW(CW + 1)) u_col_clamp (
        .pos     (cur_col),
        .extent  (eff_w),
        .outside (col_out),
        .idx     (col_idx)
    );

    // Tap (i,j) lives at bits [(i*KERNEL_N+j)*PIXEL_W +: PIXEL_W]; reserved mode acts as ZERO.
    always_comb begin
        masked = '0;
        src    = 0;
        for (int i = 0; i < KERNEL_N; i++) begin
            for (int j = 0; j < KERNEL_N; j++) begin
                src = i * KERNEL_N + j;
                if (row_out[i] || col_out[j]) begin
                    case (eff_mode)
                        MASK_CONST: masked[(i*KERNEL_N+j)*PIXEL_W +: PIXEL_W] = eff_const;
                        MASK_REPLICATE: begin
                            src = int'(row_idx[i*IW +: IW]) * KERNEL_N + int'(col_idx[j*IW +: IW]);
                            masked[(i*KERNEL_N+j)*PIXEL_W +: PIXEL_W] = in_kernel_i[src*PIXEL_W +: PIXEL_W];
                        end
                        default: masked[(i*KERNEL_N+j)*PIXEL_W +: PIXEL_W] = '0;
                    endcase
                end else begin
                    masked[(i*KERNEL_N+j)*PIXEL_W +: PIXEL_W] = in_kernel_i[src*PIXEL_W +: PIXEL_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld_o    <= 1'b0;
            out_sof_o    <= 1'b0;
            out_eol_o    <= 1'b0;
            out_eof_o    <= 1'b0;
            out_kernel_o <= '0;
            err_o        <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            in_frame_q   <= 1'b0;
            mode_q       <= MASK_ZERO;
            const_q      <= '0;
            w_q          <= (CW + 1)'(1);
            h_q          <= (RW + 1)'(1);
        end else begin
            if (in_rdy_o) out_vld_o <= in_vld_i;
            if (accept) begin
                out_kernel_o <= masked;
                out_sof_o    <= in_sof_i;
                out_eol_o    <= eol;
                out_eof_o    <= eof;
                if (in_sof_i) begin
                    mode_q  <= cfg_mode_i;
                    const_q <= cfg_const_i;
                    w_q     <= cfg_w_i;
                    h_q     <= cfg_h_i;
                end
                // SOF inside a frame, or a non-SOF beat outside one, is a framing error.
                if (in_sof_i == in_frame_q) err_o <= 1'b1;
                if (eof) begin
                    col_q      <= '0;
                    row_q      <= '0;
                    in_frame_q <= 1'b0;
                end else if (eol) begin
                    col_q      <= '0;
                    row_q      <= cur_row + 1'b1;
                    in_frame_q <= 1'b1;
                end else begin
                    col_q      <= cur_col + 1'b1;
                    row_q      <= cur_row;
                    in_frame_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mask_stream.sv
// Bench for conv_mask_stream: directed vector table, hand-built edge cases and a
// scoreboard against an image-coordinate reference model.
module tb_conv_mask_stream;

    localparam int KW3 = 72;
    localparam int KW5 = 200;

    typedef struct {
        logic       sof;
        logic       eol;
        logic       eof;
        logic [8:0] omask;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_const;
    logic [11:0] cfg_w, cfg_h;
    logic in_vld, in_sof, out_rdy;
    logic [KW3-1:0] in_k3, out_k3;
    logic [KW5-1:0] in_k5, out_k5;
    logic in_rdy3, out_vld3, out_sof3, out_eol3, out_eof3, err3;
    logic in_rdy5, out_vld5, out_sof5, out_eol5, out_eof5, err5;

    int n_checks = 0;
    int n_errors = 0;

    logic [KW3+2:0] exp_q[$];
    int   m_row, m_col, m_w, m_h;
    logic [1:0] m_mode;
    logic [7:0] m_const;
    logic m_in_frame;
    int   g_left, g_w, g_h;

    always #5 clk = ~clk;

    conv_mask_stream #(.KERNEL_N(3), .PIXEL_W(8)) u_dut3 (
        .clk(clk), .arst_n(arst_n), .cfg_mode_i(cfg_mode), .cfg_const_i(cfg_const),
        .cfg_w_i(cfg_w), .cfg_h_i(cfg_h), .in_vld_i(in_vld), .in_rdy_o(in_rdy3),
        .in_sof_i(in_sof), .in_kernel_i(in_k3), .out_vld_o(out_vld3), .out_rdy_i(out_rdy),
        .out_sof_o(out_sof3), .out_eol_o(out_eol3), .out_eof_o(out_eof3),
        .out_kernel_o(out_k3), .err_o(err3)
    );

    conv_mask_stream #(.KERNEL_N(5), .PIXEL_W(8)) u_dut5 (
        .clk(clk), .arst_n(arst_n), .cfg_mode_i(cfg_mode), .cfg_const_i(cfg_const),
        .cfg_w_i(cfg_w), .cfg_h_i(cfg_h), .in_vld_i(in_vld), .in_rdy_o(in_rdy5),
        .in_sof_i(in_sof), .in_kernel_i(in_k5), .out_vld_o(out_vld5), .out_rdy_i(out_rdy),
        .out_sof_o(out_sof5), .out_eol_o(out_eol5), .out_eof_o(out_eof5),
        .out_kernel_o(out_k5), .err_o(err5)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: clamp the image coordinate, then map back into the window.
    function automatic logic [KW3-1:0] model_win(int row, int col, int w, int h,
                                                 logic [1:0] mode, logic [7:0] cst,
                                                 logic [KW3-1:0] win);
        logic [KW3-1:0] r;
        int rr, cc, sr, sc;
        r = win;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = row + i - 1;
                cc = col + j - 1;
                if (rr < 0 || rr >= h || cc < 0 || cc >= w) begin
                    if (mode == 2'd1) begin
                        r[(i*3+j)*8 +: 8] = cst;
                    end else if (mode == 2'd2) begin
                        sr = clampi(rr, 0, h - 1) - row + 1;
                        sc = clampi(cc, 0, w - 1) - col + 1;
                        r[(i*3+j)*8 +: 8] = win[(sr*3+sc)*8 +: 8];
                    end else begin
                        r[(i*3+j)*8 +: 8] = 8'h00;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [KW3-1:0] pat3(int b);
        logic [KW3-1:0] w;
        for (int t = 0; t < 9; t++) w[t*8 +: 8] = 8'((b << 4) | t);
        return w;
    endfunction

    function automatic logic [KW3-1:0] rnd3();
        logic [KW3-1:0] w;
        for (int t = 0; t < 9; t++) w[t*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; m_w = 1; m_h = 1;
        m_mode = 2'd0; m_const = 8'h00; m_in_frame = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push();
        logic eol, eof;
        if (in_sof || !m_in_frame) begin
            if (in_sof) begin
                m_w = int'(cfg_w); m_h = int'(cfg_h); m_mode = cfg_mode; m_const = cfg_const;
            end
            m_row = 0; m_col = 0;
        end
        eol = (m_col == m_w - 1);
        eof = eol && (m_row == m_h - 1);
        exp_q.push_back({in_sof, eol, eof, model_win(m_row, m_col, m_w, m_h, m_mode, m_const, in_k3)});
        if (eof) begin
            m_row = 0; m_col = 0; m_in_frame = 1'b0;
        end else if (eol) begin
            m_col = 0; m_row++; m_in_frame = 1'b1;
        end else begin
            m_col++; m_in_frame = 1'b1;
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0; in_vld = 1'b0; in_sof = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // One clock of scoreboarded traffic: retire the shown output, then log the input beat.
    task automatic sb_cycle(input logic v, input logic r, output logic acc);
        in_vld = v;
        out_rdy = r;
        acc = 1'b0;
        @(negedge clk);
        if (out_vld3 && out_rdy) begin
            if (exp_q.size() == 0) check("sb_qdepth", 256'(exp_q.size()), 256'd1);
            else check("sb_beat", {out_sof3, out_eol3, out_eof3, out_k3}, exp_q.pop_front());
        end
        if (in_vld && in_rdy3) begin
            model_push();
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) sb_cycle(1'b0, 1'b1, acc);
        check("sb_drain", 256'(exp_q.size()), 256'd0);
    endtask

    task automatic apply(input logic sof);
        in_vld = 1'b1; in_sof = sof; out_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0; in_sof = 1'b0;
    endtask

    task automatic gen_beat();
        if (g_left == 0) begin
            g_w = $urandom_range(1, 6);
            g_h = $urandom_range(1, 4);
            g_left = g_w * g_h;
            in_sof = 1'b1;
            cfg_w = 12'(g_w);
            cfg_h = 12'(g_h);
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_const = 8'($urandom_range(0, 255));
        end else begin
            in_sof = 1'b0;
            cfg_w = 12'($urandom_range(1, 6));
            cfg_h = 12'($urandom_range(1, 4));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_const = 8'($urandom_range(0, 255));
        end
        g_left--;
        in_k3 = rnd3();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        logic [KW3-1:0] expk, held, win;
        logic [KW5-1:0] exp5;
        logic acc;
        int b, n_acc;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 9'h04F};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 9'h007};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 9'h007};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 9'h127};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 9'h049};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 9'h000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 9'h000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 9'h124};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 9'h1C9};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 9'h1C0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 9'h1C0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 9'h1E4};

        arst_n = 1'b0;
        cfg_mode = 2'd0; cfg_const = 8'h00; cfg_w = 12'd4; cfg_h = 12'd3;
        in_vld = 1'b0; in_sof = 1'b0; out_rdy = 1'b1;
        in_k3 = '0; in_k5 = '0;
        do_reset();

        check("rst_vld", out_vld3, 1'b0);
        check("rst_flags", {out_sof3, out_eol3, out_eof3}, 3'b000);
        check("rst_kernel", out_k3, '0);
        check("rst_err", err3, 1'b0);
        check("rst_rdy", in_rdy3, 1'b1);

        // ZERO then CONST over a 4x3 frame
        for (int pass = 0; pass < 2; pass++) begin
            cfg_mode = (pass == 0) ? 2'd0 : 2'd1;
            cfg_const = 8'hA5;
            cfg_w = 12'd4; cfg_h = 12'd3;
            for (int v = 0; v < 12; v++) begin
                in_k3 = pat3(v + 1);
                apply(vecs[v].sof);
                for (int t = 0; t < 9; t++)
                    expk[t*8 +: 8] = vecs[v].omask[t] ? ((pass == 0) ? 8'h00 : 8'hA5) : in_k3[t*8 +: 8];
                check("tbl_kernel", out_k3, expk);
                check("tbl_flags", {out_vld3, out_sof3, out_eol3, out_eof3},
                      {1'b1, vecs[v].sof, vecs[v].eol, vecs[v].eof});
            end
        end
        check("tbl_err", err3, 1'b0);

        // K=5 REPLICATE at the top-left corner
        do_reset();
        cfg_mode = 2'd2; cfg_w = 12'd8; cfg_h = 12'd8;
        for (int t = 0; t < 25; t++) in_k5[t*8 +: 8] = 8'(8'h40 + t);
        in_k5[12*8 +: 8] = 8'h11;
        in_k5[13*8 +: 8] = 8'h22;
        in_k5[17*8 +: 8] = 8'h33;
        apply(1'b1);
        check("k5_tap00", out_k5[0 +: 8], 8'h11);
        check("k5_tap03", out_k5[3*8 +: 8], 8'h22);
        check("k5_tap30", out_k5[15*8 +: 8], 8'h33);
        check("k5_tap04", out_k5[4*8 +: 8], in_k5[14*8 +: 8]);
        check("k5_tap40", out_k5[20*8 +: 8], in_k5[22*8 +: 8]);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                exp5[(i*5+j)*8 +: 8] = in_k5[(((i < 2) ? 2 : i)*5 + ((j < 2) ? 2 : j))*8 +: 8];
        check("k5_window", out_k5, exp5);
        check("k5_flags", {out_sof5, out_eol5, out_eof5}, 3'b100);

        // Backpressure: 5 stalled cycles in the middle of a REPLICATE frame
        do_reset();
        cfg_mode = 2'd2; cfg_w = 12'd4; cfg_h = 12'd3; cfg_const = 8'h00;
        b = 0;
        in_sof = 1'b1; in_k3 = pat3(1);
        for (int c = 0; c < 3; c++) begin
            sb_cycle(1'b1, 1'b1, acc);
            if (acc) begin b++; in_sof = 1'b0; in_k3 = pat3(b + 1); end
        end
        held = out_k3;
        for (int c = 0; c < 5; c++) begin
            sb_cycle(1'b1, 1'b0, acc);
            check("stall_rdy", in_rdy3, 1'b0);
            check("stall_vld", out_vld3, 1'b1);
            check("stall_data", out_k3, held);
        end
        for (int c = 0; c < 40 && b < 12; c++) begin
            sb_cycle(1'b1, 1'b1, acc);
            if (acc) begin b++; in_sof = 1'b0; in_k3 = pat3(b + 1); end
        end
        check("stall_beats", 256'(b), 256'd12);
        drain();

        // Random frames, random valid/ready, config churn between SOFs
        do_reset();
        g_left = 0;
        n_acc = 0;
        gen_beat();
        for (int c = 0; c < 6000 && n_acc < 1000; c++) begin
            sb_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, acc);
            if (acc) begin n_acc++; gen_beat(); end
        end
        check("rand_beats", 256'(n_acc), 256'd1000);
        drain();
        check("rand_err", err3, 1'b0);

        // SOF at (1,2) restarts with new config; non-SOF after EOF is a fresh frame
        do_reset();
        check("ferr_clean", err3, 1'b0);
        cfg_mode = 2'd0; cfg_const = 8'h00; cfg_w = 12'd4; cfg_h = 12'd3;
        for (int v = 0; v < 6; v++) begin
            in_sof = (v == 0); in_k3 = pat3(v + 1);
            sb_cycle(1'b1, 1'b1, acc);
        end
        check("ferr_before", err3, 1'b0);
        cfg_mode = 2'd1; cfg_const = 8'hA5; cfg_w = 12'd3; cfg_h = 12'd2;
        in_sof = 1'b1; in_k3 = pat3(7);
        sb_cycle(1'b1, 1'b1, acc);
        check("ferr_set", err3, 1'b1);
        check("ferr_sof", out_sof3, 1'b1);
        check("ferr_tap0", out_k3[0 +: 8], 8'hA5);
        check("ferr_tap4", out_k3[4*8 +: 8], in_k3[4*8 +: 8]);
        cfg_mode = 2'd0; cfg_w = 12'd4; cfg_h = 12'd3;
        for (int v = 0; v < 5; v++) begin
            in_sof = 1'b0; in_k3 = pat3(8 + v);
            sb_cycle(1'b1, 1'b1, acc);
        end
        check("ferr_eof", {out_eol3, out_eof3}, 2'b11);
        in_sof = 1'b0; in_k3 = pat3(13);
        sb_cycle(1'b1, 1'b1, acc);
        check("ferr_sticky", err3, 1'b1);
        check("ferr_nosof", {out_sof3, out_eol3, out_eof3}, 3'b000);
        check("ferr_held_cfg", out_k3[0 +: 8], 8'hA5);
        drain();

        // Single-pixel REPLICATE frames, then asynchronous reset mid-frame
        do_reset();
        cfg_mode = 2'd2; cfg_w = 12'd1; cfg_h = 12'd1;
        for (int v = 0; v < 2; v++) begin
            in_sof = 1'b1; in_k3 = rnd3();
            sb_cycle(1'b1, 1'b1, acc);
            for (int t = 0; t < 9; t++) expk[t*8 +: 8] = in_k3[4*8 +: 8];
            check("px1_kernel", out_k3, expk);
            check("px1_flags", {out_sof3, out_eol3, out_eof3}, 3'b111);
        end
        check("px1_err", err3, 1'b0);
        cfg_mode = 2'd0; cfg_w = 12'd4; cfg_h = 12'd3;
        for (int v = 0; v < 3; v++) begin
            in_sof = (v != 1); in_k3 = rnd3();
            sb_cycle(1'b1, 1'b1, acc);
        end
        check("arst_pre_err", err3, 1'b1);
        check("arst_pre_vld", out_vld3, 1'b1);
        arst_n = 1'b0;
        in_vld = 1'b0;
        #1;
        check("arst_vld", out_vld3, 1'b0);
        check("arst_err", err3, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        in_sof = 1'b0; in_k3 = rnd3();
        win = in_k3;
        sb_cycle(1'b1, 1'b1, acc);
        check("arst_nosof_err", err3, 1'b1);
        check("arst_nosof_flags", {out_sof3, out_eol3, out_eof3}, 3'b011);
        for (int t = 0; t < 9; t++) expk[t*8 +: 8] = (t == 4) ? win[4*8 +: 8] : 8'h00;
        check("arst_nosof_kernel", out_k3, expk);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
